// File: rtl/dspl_pkg.sv
// rtl/dspl_pkg.sv - shared digit-word layout and seven-segment glyph table
// Digit word is {en, val[3:0], dp}; glyphs are active-high abcdefg with a at bit 6.
package dspl_pkg;

    localparam int DIGIT_W = 6;
    localparam int EN_BIT  = 5;
    localparam int VAL_MSB = 4;
    localparam int VAL_LSB = 1;
    localparam int DP_BIT  = 0;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/dspl_scan_ctrl_if.sv
// rtl/dspl_scan_ctrl_if.sv - display scan controller host/display bundle
// master: drives digits, blink_mask, load, brightness; observes an, dec_cat, frame_done.
// slave : the scan controller side of the same signals.
interface dspl_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    logic [dspl_pkg::DIGIT_W*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]                   blink_mask;
    logic                                  load;
    logic [3:0]                            brightness;
    logic [N_DIGITS-1:0]                   an;
    logic [7:0]                            dec_cat;
    logic                                  frame_done;

    modport master (
        output digits, blink_mask, load, brightness,
        input  an, dec_cat, frame_done
    );

    modport slave (
        input  digits, blink_mask, load, brightness,
        output an, dec_cat, frame_done
    );
endinterface

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex to active-low seven-segment decoder
// val   : 4-bit hex value
// seg_n : segments a..g (bit 6 = a), active-low
module hex7seg
    import dspl_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg_n
);
    assign seg_n = ~SEG_GLYPH[val];
endmodule

// File: rtl/dspl_scan_ctrl.sv
// rtl/dspl_scan_ctrl.sv - multiplexed seven-segment scan controller with double buffer, blink and PWM
// clock/reset : system clock, synchronous active-high reset
// bus         : digits/blink_mask/load/brightness in; an/dec_cat/frame_done out
module dspl_scan_ctrl
    import dspl_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_LOG2 = 17,
    parameter int BLINK_LOG2   = 5
) (
    input  logic              clock,
    input  logic              reset,
    dspl_scan_ctrl_if.slave   bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BUF_W = DIGIT_W * N_DIGITS;

    logic [REFRESH_LOG2-1:0] tick;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_LOG2-1:0]   frame_cnt;
    logic                    pending;
    logic [BUF_W-1:0]        stage_digits;
    logic [BUF_W-1:0]        act_digits;
    logic [N_DIGITS-1:0]     stage_blink;
    logic [N_DIGITS-1:0]     act_blink;

    logic [N_DIGITS-1:0]     an_q;
    logic [7:0]              dec_q;
    logic                    frame_done_q;

    logic                    slot_end;
    logic                    wrap;
    logic [DIGIT_W-1:0]      cur_word;
    logic                    bright_ok;
    logic                    lit;
    logic [6:0]              seg_n;
    logic [N_DIGITS-1:0]     an_next;
    logic [7:0]              dec_next;

    assign slot_end = &tick;
    assign wrap     = slot_end && (idx == IDX_W'(N_DIGITS - 1));

    assign cur_word  = act_digits[int'(idx)*DIGIT_W +: DIGIT_W];
    // PWM compares the top four tick bits against the level, so 0 still gives 1/16 duty.
    assign bright_ok = tick[REFRESH_LOG2-1 -: 4] <= bus.brightness;
    assign lit       = cur_word[EN_BIT]
                       && !(act_blink[idx] && frame_cnt[BLINK_LOG2-1])
                       && bright_ok;

    hex7seg u_hex7seg (
        .val   (cur_word[VAL_MSB:VAL_LSB]),
        .seg_n (seg_n)
    );

    // Glyph and anode are computed from the same index and registered together.
    assign an_next  = lit ? ~(N_DIGITS'(1) << idx) : '1;
    assign dec_next = lit ? {seg_n, ~cur_word[DP_BIT]} : 8'hFF;

    always_ff @(posedge clock) begin
        if (reset) begin
            tick         <= '0;
            idx          <= '0;
            frame_cnt    <= '0;
            pending      <= 1'b0;
            stage_digits <= '0;
            act_digits   <= '0;
            stage_blink  <= '0;
            act_blink    <= '0;
            an_q         <= '1;
            dec_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            tick <= tick + 1'b1;
            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            frame_done_q <= wrap;

            // A load on the wrap cycle bypasses staging so it shows in the frame that starts now.
            if (wrap && bus.load) begin
                act_digits <= bus.digits;
                act_blink  <= bus.blink_mask;
                pending    <= 1'b0;
            end else if (wrap && pending) begin
                act_digits <= stage_digits;
                act_blink  <= stage_blink;
                pending    <= 1'b0;
            end else if (bus.load) begin
                stage_digits <= bus.digits;
                stage_blink  <= bus.blink_mask;
                pending      <= 1'b1;
            end

            an_q  <= an_next;
            dec_q <= dec_next;
        end
    end

    assign bus.an         = an_q;
    assign bus.dec_cat    = dec_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dspl_scan_ctrl.sv
// tb/tb_dspl_scan_ctrl.sv - scoreboard testbench for dspl_scan_ctrl
module tb_dspl_scan_ctrl;
    localparam int ND    = 4;
    localparam int RL    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = 1 << RL;
    localparam int FRAME = SLOT * ND;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dspl_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

    dspl_scan_ctrl #(
        .N_DIGITS     (ND),
        .REFRESH_LOG2 (RL),
        .BLINK_LOG2   (BL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] dec;
        logic       fd;
    } exp_t;

    typedef struct {
        int          sl;
        logic [23:0] d;
        logic [3:0]  b;
    } load_t;

    exp_t  exp_q[$];
    load_t loads[$];
    int    s = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    logic [23:0] cur_d  = '0;
    logic [3:0]  cur_b  = '0;
    logic [3:0]  cur_br = 4'd15;

    // Active-low abcdefg glyphs, written out by hand.
    logic [6:0] glyph_n [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Expected outputs produced by the edge leaving scan position st.
    // A load made at position sl becomes visible from the next frame boundary after sl.
    function automatic exp_t model(input int st, input logic [3:0] br);
        exp_t        e;
        int          pos, di, tk, f;
        bit          phase, lit;
        logic [23:0] d;
        logic [3:0]  b;
        logic [5:0]  w;
        pos   = st % FRAME;
        di    = pos / SLOT;
        tk    = pos % SLOT;
        f     = st / FRAME;
        phase = (f % 4) >= 2;
        d = '0;
        b = '0;
        for (int i = loads.size() - 1; i >= 0; i--) begin
            if ((loads[i].sl / FRAME + 1) * FRAME <= st) begin
                d = loads[i].d;
                b = loads[i].b;
                break;
            end
        end
        w   = d[di*6 +: 6];
        lit = w[5] && !(b[di] && phase) && (tk <= int'(br));
        e.an  = lit ? ~(4'd1 << di) : 4'hF;
        e.dec = lit ? {glyph_n[w[4:1]], ~w[0]} : 8'hFF;
        e.fd  = (pos == FRAME - 1);
        return e;
    endfunction

    task automatic step(input logic rst, input logic ld);
        exp_t e;
        reset          = rst;
        bus.load       = ld;
        bus.digits     = cur_d;
        bus.blink_mask = cur_b;
        bus.brightness = cur_br;
        if (rst) begin
            e.an = 4'hF; e.dec = 8'hFF; e.fd = 1'b0;
        end else begin
            e = model(s, cur_br);
        end
        @(posedge clock);
        exp_q.push_back(e);
        if (rst) begin
            s = 0;
            loads.delete();
        end else begin
            if (ld) loads.push_back('{s, cur_d, cur_b});
            s++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FRAME; i++) begin
            if (s % FRAME == p) break;
            step(1'b0, 1'b0);
        end
    endtask

    task automatic load_now(input logic [23:0] d, input logic [3:0] b);
        cur_d = d;
        cur_b = b;
        step(1'b0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("an", {4'h0, bus.an}, {4'h0, e.an});
            chk("dec_cat", bus.dec_cat, e.dec);
            chk("frame_done", {7'h0, bus.frame_done}, {7'h0, e.fd});
        end
    end

    initial begin
        bus.load       = 1'b0;
        bus.digits     = '0;
        bus.blink_mask = '0;
        bus.brightness = 4'd15;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(100);

        // Every digit shows "3" at full brightness.
        cur_br = 4'd15;
        load_now({4{6'b1_0011_0}}, 4'b0000);
        idle(150);

        cur_br = 4'd3;
        idle(130);

        cur_br = 4'd15;
        load_now({4{6'b1_0011_0}}, 4'b0010);
        idle(FRAME * 5);

        // Two loads in one frame: only the later one appears.
        wait_pos(10);
        load_now({4{6'b1_0001_0}}, 4'b0000);
        wait_pos(30);
        load_now({4{6'b1_0010_1}}, 4'b0000);
        idle(FRAME);

        // Load exactly on the wrap cycle.
        wait_pos(FRAME - 1);
        load_now({6'b1_1010_0, 6'b1_0101_1, 6'b0_0111_0, 6'b1_1111_0}, 4'b0000);
        idle(80);

        // Reset mid-slot with a load still pending.
        wait_pos(5);
        load_now({4{6'b1_1000_1}}, 4'b0000);
        wait_pos(20);
        step(1'b1, 1'b0);
        idle(150);

        for (int i = 0; i < 1500; i++) begin
            logic ld;
            ld = ($urandom % 50 == 0) || ((s % FRAME == FRAME - 1) && ($urandom % 4 == 0));
            if (ld) begin
                cur_d = 24'($urandom);
                cur_b = 4'($urandom);
            end
            if ($urandom % 40 == 0) cur_br = 4'($urandom);
            step(($urandom % 700) == 0, ld);
        end

        idle(2);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dspl_scan_ctrl.md
DSPL_SCAN_CTRL -- requirements
Module: dspl_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits; legal range 1..16.
REQ-002 Parameter REFRESH_LOG2, default 17: each digit slot lasts 2**REFRESH_LOG2 clocks; minimum 4.
REQ-003 Parameter BLINK_LOG2, default 5: blink half-period is 2**(BLINK_LOG2-1) frames; minimum 1.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 digits  in  6*N_DIGITS  packed digit words; digit k at bits [6k+5:6k]; each word is {en, val[3:0], dp}.
REQ-007 blink_mask  in  N_DIGITS  bit k=1 makes digit k blink.
REQ-008 load  in  1  one-cycle strobe; captures digits and blink_mask.
REQ-009 brightness  in  4  PWM level; 0 = 1/16 duty, 15 = full duty; sampled continuously.
REQ-010 an  out  N_DIGITS  anode enables, active-low; bit k drives digit k.
REQ-011 dec_cat  out  8  cathodes, active-low; [7:1] = segments a..g, [0] = dp.
REQ-012 frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.

Function
REQ-013 Tick counter of REFRESH_LOG2 bits increments every clock; at all-ones it wraps to 0 and the digit index advances.
REQ-014 Digit index counts 0..N_DIGITS-1 and wraps to 0; frame_done asserts on the cycle after the wrap.
REQ-015 Double buffer: load=1 writes digits/blink_mask into a staging buffer and sets pending; on frame wrap with pending set, staging copies into the active buffer and pending clears.
REQ-016 If load coincides with the frame-wrap cycle, the incoming inputs go directly into the active buffer and pending clears.
REQ-017 Repeated loads before a frame wrap: the last one wins; earlier ones are discarded.
REQ-018 Frame counter of BLINK_LOG2 bits increments on every frame wrap; blink_phase = its MSB.
REQ-019 Current digit is lit only when en=1, AND NOT (blink_mask[k]=1 AND blink_phase=1), AND tick[REFRESH_LOG2-1 -: 4] <= brightness.
REQ-020 Lit digit: exactly one an bit low (index k); dec_cat[7:1] = hex decode of val (0-F, standard 7-seg glyphs, active-low); dec_cat[0] = ~dp.
REQ-021 Unlit digit: an all ones, dec_cat = 8'hFF.
REQ-022 an and dec_cat are registered; they reflect the index/tick state with exactly 1 clock latency.
REQ-023 Glyph and anode change in the same cycle; no cycle shows the new anode with the old glyph.

Reset
REQ-024 On reset: an = all ones, dec_cat = 8'hFF, frame_done = 0.
REQ-025 On reset: tick, index, frame counter, pending and both buffers cleared (all digits disabled).
REQ-026 Reset mid-frame or mid-load takes effect on the next edge; the staged load is discarded.

Structure
REQ-027 Shared package dspl_pkg holds the digit word width (6), field offsets (EN=5, VAL=4:1, DP=0) and the 16-entry segment glyph table.
REQ-028 Hex-to-segment decoding is one combinational sub-module, hex7seg; everything else stays in dspl_scan_ctrl.

Verification (N_DIGITS=4, REFRESH_LOG2=4, BLINK_LOG2=2)
REQ-029 Reset, then idle 100 cycles -> an=4'hF, dec_cat=8'hFF, frame_done pulses every 64 cycles.
REQ-030 load digits={1,4'h3,0}x4, brightness=15 -> after the next frame_done, each digit lit in turn for 16 cycles; dec_cat=8'h0D ("3").
REQ-031 brightness=3 -> each digit lit only while tick[3:0] <= 3 (4 of 16 cycles) and dark for the other 12.
REQ-032 blink_mask=4'b0010 -> digit 1 lit for 2 frames, dark for 2 frames; other digits lit continuously.
REQ-033 load val=1 then val=2 in the same frame -> the next frame shows only "2"; load on the wrap cycle is visible in that same frame.
REQ-034 reset asserted mid-slot with pending set -> next cycle an=4'hF; after release the display stays dark until a new load.
